pw_frame_rx: RTL

Parametrised pulse-width serial frame receiver. It decodes bits on `rxd` from the length of each space (low) interval and assembles `FRAME_BITS`-bit frames. When the address field matches `ref`, it presents the payload field through a valid/ack handshake. It sits between the serial line pin and a downstream consumer and adds framing-error, gap-timeout and overrun reporting.

---
 rtl/pw_frame_rx_if.sv | 44 ++++
 rtl/pw_frame_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pw_frame_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pw_frame_rx_if                                                  |
// | Purpose  : Output bus of the pulse-width frame receiver: decoded payload   |
// |            with a valid/ack handshake, plus a one-cycle error report.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   out_data  [PW-1:0]  payload of the last accepted frame (master -> slave) |
// |   out_valid           out_data holds unconsumed data   (master -> slave)   |
// |   out_ack             consumer takes data this edge    (slave  -> master)  |
// |   err                 one-cycle error pulse            (master -> slave)   |
// |   err_code  [1:0]     01 space too long, 10 gap timeout, 11 overrun        |
// |                                                                            |
// | PW must equal FRAME_BITS-ADDR_BITS of the receiver it is bound to.         |
// +----------------------------------------------------------------------------+
interface pw_frame_rx_if #(
  parameter int PW = 3
);
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ack;
  logic          err;
  logic [1:0]    err_code;

  // Receiver side
  modport master (
    output out_data,
    output out_valid,
    output err,
    output err_code,
    input  out_ack
  );

  // Consumer side
  modport slave (
    input  out_data,
    input  out_valid,
    input  err,
    input  err_code,
    output out_ack
  );
endinterface
`default_nettype wire

// File: rtl/pw_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pw_frame_rx                                                     |
// | Purpose  : Pulse-width serial frame receiver. Each bit is encoded by the   |
// |            length of a space (rxd low) interval: short spaces decode as 1, |
// |            long spaces as 0. FRAME_BITS bits form a frame whose top        |
// |            ADDR_BITS are an address; frames addressed to ref_addr present  |
// |            their payload on a valid/ack handshake. Over-long spaces, long  |
// |            marks inside a partial frame and unconsumed data being hit by a |
// |            new frame are reported as one-cycle error pulses.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clock      in   single clock, all state on posedge                       |
// |   reset_     in   asynchronous, active-high reset                          |
// |   rxd        in   serial line (mark = 1, space = 0), already synchronised  |
// |   ref_addr   in   station address [ADDR_BITS-1:0], sampled in CHECK        |
// |                   ("ref" itself is a reserved word in SystemVerilog)       |
// |   bus        pw_frame_rx_if.master: out_data, out_valid, out_ack, err,     |
// |                   err_code                                                 |
// |                                                                            |
// | Parameter constraints: FRAME_BITS-ADDR_BITS >= 1, ADDR_BITS >= 1,          |
// | MAX_SPACE >= THRESH.                                                       |
// +----------------------------------------------------------------------------+
module pw_frame_rx #(
  parameter int FRAME_BITS = 8,
  parameter int ADDR_BITS  = 5,
  parameter int THRESH     = 8,
  parameter int MAX_SPACE  = 15,
  parameter int GAP_MAX    = 31,
  parameter int MSB_FIRST  = 0
) (
  input  logic                 clock,
  input  logic                 reset_,
  input  logic                 rxd,
  input  logic [ADDR_BITS-1:0] ref_addr,
  pw_frame_rx_if.master        bus
);

  localparam int PW = FRAME_BITS - ADDR_BITS;
  localparam int SW = $clog2(MAX_SPACE + 2);
  localparam int GW = $clog2(GAP_MAX + 2);
  localparam int BW = $clog2(FRAME_BITS + 1);

  // Counter limits pre-cast to counter width. "Would exceed the limit" is
  // tested as "already at the limit", so no counter ever needs a wider sum.
  localparam logic [SW-1:0] SPACE_LIM = SW'(MAX_SPACE);
  localparam logic [SW-1:0] ONE_LIM   = SW'(THRESH);
  localparam logic [GW-1:0] GAP_LIM   = GW'(GAP_MAX);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

  localparam logic [1:0] CODE_SPACE   = 2'b01;
  localparam logic [1:0] CODE_GAP     = 2'b10;
  localparam logic [1:0] CODE_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // line marking between bits / frames
    ST_SPACE = 3'd1,  // measuring a space
    ST_FLUSH = 3'd2,  // waiting out an over-long space
    ST_STORE = 3'd3,  // shift the decoded bit in
    ST_CHECK = 3'd4   // full frame: address compare and handoff
  } state_t;

  state_t                state_q,     state_d;
  logic [FRAME_BITS-1:0] shift_q,     shift_d;
  logic [BW-1:0]         bit_cnt_q,   bit_cnt_d;
  logic [SW-1:0]         space_cnt_q, space_cnt_d;
  logic [GW-1:0]         gap_cnt_q,   gap_cnt_d;
  logic [PW-1:0]         data_q,      data_d;
  logic                  valid_q,     valid_d;
  logic                  err_q,       err_d;
  logic [1:0]            code_q,      code_d;

  // Bit value of the space just measured; the space counter still holds L
  // while in STORE.
  logic                  bit_val;
  logic [FRAME_BITS-1:0] shift_in;
  logic                  addr_match;

  assign bit_val    = (space_cnt_q < ONE_LIM);
  assign addr_match = (shift_q[FRAME_BITS-1:PW] == ref_addr);

  // Shift direction decides where the first received bit ends up:
  // right shift leaves it in frame[0], left shift in frame[FRAME_BITS-1].
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_in = {shift_q[FRAME_BITS-2:0], bit_val};
    end else begin : g_lsb_first
      assign shift_in = {bit_val, shift_q[FRAME_BITS-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    space_cnt_d = space_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    // An ack consumes the data unless CHECK reloads it in the same cycle.
    valid_d     = valid_q & ~bus.out_ack;
    err_d       = 1'b0;
    code_d      = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (!rxd) begin
          state_d     = ST_SPACE;
          space_cnt_d = SW'(1);
          gap_cnt_d   = '0;
        end else if (bit_cnt_q != '0) begin
          // Only marks inside a partial frame are timed.
          if (gap_cnt_q == GAP_LIM) begin
            err_d     = 1'b1;
            code_d    = CODE_GAP;
            bit_cnt_d = '0;
            shift_d   = '0;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      ST_SPACE: begin
        if (!rxd) begin
          if (space_cnt_q == SPACE_LIM) begin
            err_d       = 1'b1;
            code_d      = CODE_SPACE;
            bit_cnt_d   = '0;
            shift_d     = '0;
            space_cnt_d = '0;
            state_d     = ST_FLUSH;
          end else begin
            space_cnt_d = space_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_STORE;
        end
      end

      ST_FLUSH: begin
        if (rxd) begin
          state_d = ST_IDLE;
        end
      end

      ST_STORE: begin
        shift_d     = shift_in;
        bit_cnt_d   = bit_cnt_q + 1'b1;
        space_cnt_d = '0;
        state_d     = (bit_cnt_q == LAST_BIT) ? ST_CHECK : ST_IDLE;
      end

      ST_CHECK: begin
        if (addr_match) begin
          if (!valid_q || bus.out_ack) begin
            data_d  = shift_q[PW-1:0];
            valid_d = 1'b1;
          end else begin
            // Consumer still holds the previous payload: keep it, report.
            err_d  = 1'b1;
            code_d = CODE_OVERRUN;
          end
        end
        bit_cnt_d = '0;
        shift_d   = '0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      space_cnt_q <= '0;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      space_cnt_q <= space_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;

endmodule
`default_nettype wire
